// File: rtl/vga_timing_gen.sv
// Raster timing source for the VGA video path.
// Generates the pixel-rate strobe, beam coordinates, active-area flag,
// h/v sync and line/frame start pulses. Every output is a register loaded
// on the same pixel tick, so all of them describe the same pixel.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    output logic           pix_en,
    output logic [X_W-1:0] counter_x,
    output logic [Y_W-1:0] counter_y,
    output logic           in_display_area,
    output logic           vga_h_sync,
    output logic           vga_v_sync,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    // A one-bit divider is kept even for CLK_DIV=1; it simply never moves.
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);

    generate
        if (2 ** X_W < H_TOTAL) begin : g_bad_x_w
            $error("vga_timing_gen: X_W too narrow for H_TOTAL");
        end
        if (2 ** Y_W < V_TOTAL) begin : g_bad_y_w
            $error("vga_timing_gen: Y_W too narrow for V_TOTAL");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [X_W-1:0]   x_next;
    logic [Y_W-1:0]   y_next;
    logic             h_sync_act;
    logic             v_sync_act;
    logic             disp_next;

    // Next-pixel coordinates and the flags that describe that pixel.
    always_comb begin
        tick   = run && (div == DIV_LAST);
        x_next = (counter_x == X_LAST) ? '0 : counter_x + X_W'(1);
        y_next = counter_y;
        if (counter_x == X_LAST) begin
            y_next = (counter_y == Y_LAST) ? '0 : counter_y + Y_W'(1);
        end
        h_sync_act = (x_next >= X_W'(HS_FIRST)) && (x_next <= X_W'(HS_LAST));
        v_sync_act = (y_next >= Y_W'(VS_FIRST)) && (y_next <= Y_W'(VS_LAST));
        disp_next  = (x_next < X_W'(H_ACTIVE)) && (y_next < Y_W'(V_ACTIVE));
    end

    // Pixel-rate divider; holds its count while run is low so no pixel is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else if (run) begin
            div <= div + DIV_W'(1);
        end
    end

    // Beam position and aligned output flags, all loaded on the pixel tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en          <= 1'b0;
            counter_x       <= X_LAST;
            counter_y       <= Y_LAST;
            in_display_area <= 1'b0;
            vga_h_sync      <= ~SYNC_POL;
            vga_v_sync      <= ~SYNC_POL;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            pix_en <= tick;
            if (tick) begin
                counter_x       <= x_next;
                counter_y       <= y_next;
                in_display_area <= disp_next;
                vga_h_sync      <= h_sync_act ? SYNC_POL : ~SYNC_POL;
                vga_v_sync      <= v_sync_act ? SYNC_POL : ~SYNC_POL;
                line_start      <= (x_next == '0);
                frame_start     <= (x_next == '0) && (y_next == '0);
            end else begin
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced raster keeps full frames short.
// The reference model tracks a linear pixel index per frame and derives
// coordinates and flags from it arithmetically.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 10;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int X_W      = 5;
    localparam int Y_W      = 5;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 30
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 17
    localparam int FRAME    = H_TOTAL * V_TOTAL;                // 510
    localparam int DIV0     = 2;
    localparam int DIV1     = 1;
    localparam bit POL0     = 1'b0;
    localparam bit POL1     = 1'b1;

    typedef logic [15:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run0 = 1'b0;
    logic run1 = 1'b0;

    logic           pix_en0, disp0, hs0, vs0, ls0, fs0;
    logic [X_W-1:0] cx0;
    logic [Y_W-1:0] cy0;
    logic           pix_en1, disp1, hs1, vs1, ls1, fs1;
    logic [X_W-1:0] cx1;
    logic [Y_W-1:0] cy1;

    vec_t dv0, dv1;
    assign dv0 = {pix_en0, cx0, cy0, disp0, hs0, vs0, ls0, fs0};
    assign dv1 = {pix_en1, cx1, cy1, disp1, hs1, vs1, ls1, fs1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(DIV0), .SYNC_POL(POL0), .X_W(X_W), .Y_W(Y_W)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .run(run0), .pix_en(pix_en0),
        .counter_x(cx0), .counter_y(cy0), .in_display_area(disp0),
        .vga_h_sync(hs0), .vga_v_sync(vs0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(DIV1), .SYNC_POL(POL1), .X_W(X_W), .Y_W(Y_W)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .run(run1), .pix_en(pix_en1),
        .counter_x(cx1), .counter_y(cy1), .in_display_area(disp1),
        .vga_h_sync(hs1), .vga_v_sync(vs1), .line_start(ls1), .frame_start(fs1)
    );

    // Reference model: pixel index within the frame plus divider phase.
    int p0, d0, p1, d1;
    bit pe0, pe1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= FRAME - 1; d0 <= 0; pe0 <= 1'b0;
            p1 <= FRAME - 1; d1 <= 0; pe1 <= 1'b0;
        end else begin
            if (run0 && d0 == DIV0 - 1) begin
                d0 <= 0; p0 <= (p0 + 1) % FRAME; pe0 <= 1'b1;
            end else begin
                pe0 <= 1'b0;
                if (run0) d0 <= d0 + 1;
            end
            if (run1 && d1 == DIV1 - 1) begin
                d1 <= 0; p1 <= (p1 + 1) % FRAME; pe1 <= 1'b1;
            end else begin
                pe1 <= 1'b0;
                if (run1) d1 <= d1 + 1;
            end
        end
    end

    function automatic vec_t exp_vec(input int p, input bit pe, input bit pol);
        int x, y;
        bit hs, vs, disp;
        x    = p % H_TOTAL;
        y    = p / H_TOTAL;
        hs   = (x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC);
        vs   = (y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC);
        disp = (x < H_ACTIVE) && (y < V_ACTIVE);
        return {pe, X_W'(x), Y_W'(y), disp, hs ? pol : ~pol, vs ? pol : ~pol,
                pe && (x == 0), pe && (p == 0)};
    endfunction

    localparam vec_t RST0 = {1'b0, X_W'(H_TOTAL - 1), Y_W'(V_TOTAL - 1), 1'b0, ~POL0, ~POL0, 1'b0, 1'b0};
    localparam vec_t RST1 = {1'b0, X_W'(H_TOTAL - 1), Y_W'(V_TOTAL - 1), 1'b0, ~POL1, ~POL1, 1'b0, 1'b0};

    task automatic test_reset();
        run0 = 1'b1;
        run1 = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (dv0 !== RST0) begin
            errors++;
            $display("FAIL reset_dut0 got %h want %h", dv0, RST0);
        end
        checks++;
        if (dv1 !== RST1) begin
            errors++;
            $display("FAIL reset_dut1 got %h want %h", dv1, RST1);
        end
        run0 = 1'b0;
        run1 = 1'b0;
    endtask

    task automatic test_first_pixel();
        vec_t want;
        @(negedge clk);
        rst_n = 1'b1;
        run0  = 1'b1;
        run1  = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_en0 !== 1'b0) begin
            errors++;
            $display("FAIL first_edge1_pix got %b want 0", pix_en0);
        end
        @(negedge clk);
        want = {1'b1, X_W'(0), Y_W'(0), 1'b1, ~POL0, ~POL0, 1'b1, 1'b1};
        checks++;
        if (dv0 !== want) begin
            errors++;
            $display("FAIL first_pixel got %h want %h", dv0, want);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (pix_en0 !== 1'(i % 2) || (i % 2 == 1 && cx0 !== X_W'((i + 1) / 2))) begin
                errors++;
                $display("FAIL pix_toggle i=%0d got pix=%b x=%0d want pix=%0d x=%0d",
                         i, pix_en0, cx0, i % 2, (i + 1) / 2);
            end
        end
    endtask

    task automatic test_full_frame();
        int n = 0;
        int npix = 0, nline = 0, nframe = 0, ndisp = 0;
        int nhs5 = 0, nhs_out = 0, nvs = 0, nvs_out = 0;
        int lx = -1, ly = -1;
        vec_t want;
        while (!(pix_en0 && fs0) && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4 * FRAME) begin
            errors++;
            $display("FAIL frame_start_wait timeout got none want frame_start");
        end
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            want = exp_vec(p0, pe0, POL0);
            checks++;
            if (dv0 !== want) begin
                errors++;
                if (errors < 20) $display("FAIL frame_model0 i=%0d got %h want %h", i, dv0, want);
            end
            want = exp_vec(p1, pe1, POL1);
            checks++;
            if (dv1 !== want) begin
                errors++;
                if (errors < 20) $display("FAIL frame_model1 i=%0d got %h want %h", i, dv1, want);
            end
            if (pix_en0) begin
                if (lx == H_TOTAL - 1 && ly == 0) begin
                    checks++;
                    if ({cx0, cy0, ls0, fs0} !== {X_W'(0), Y_W'(1), 1'b1, 1'b0}) begin
                        errors++;
                        $display("FAIL line_wrap got x=%0d y=%0d ls=%b fs=%b want 0 1 1 0", cx0, cy0, ls0, fs0);
                    end
                end
                if (lx == H_TOTAL - 1 && ly == V_TOTAL - 1) begin
                    checks++;
                    if ({cx0, cy0, ls0, fs0} !== {X_W'(0), Y_W'(0), 1'b1, 1'b1}) begin
                        errors++;
                        $display("FAIL frame_wrap got x=%0d y=%0d ls=%b fs=%b want 0 0 1 1", cx0, cy0, ls0, fs0);
                    end
                end
                lx = int'(cx0);
                ly = int'(cy0);
            end
            if (i < 2 * FRAME && pix_en0) begin
                npix++;
                if (ls0) nline++;
                if (fs0) nframe++;
                if (disp0) ndisp++;
                if (hs0 == POL0 && cy0 == 5) nhs5++;
                if (hs0 == POL0 && (cx0 < H_ACTIVE + H_FP || cx0 >= H_ACTIVE + H_FP + H_SYNC)) nhs_out++;
                if (vs0 == POL0) nvs++;
                if (vs0 == POL0 && (cy0 < V_ACTIVE + V_FP || cy0 >= V_ACTIVE + V_FP + V_SYNC)) nvs_out++;
            end
            @(negedge clk);
        end
        checks++;
        if (npix != FRAME) begin errors++; $display("FAIL pix_per_frame got %0d want %0d", npix, FRAME); end
        checks++;
        if (nline != V_TOTAL) begin errors++; $display("FAIL lines_per_frame got %0d want %0d", nline, V_TOTAL); end
        checks++;
        if (nframe != 1) begin errors++; $display("FAIL frame_starts got %0d want 1", nframe); end
        checks++;
        if (ndisp != H_ACTIVE * V_ACTIVE) begin errors++; $display("FAIL display_pixels got %0d want %0d", ndisp, H_ACTIVE * V_ACTIVE); end
        checks++;
        if (nhs5 != H_SYNC) begin errors++; $display("FAIL hsync_line5 got %0d want %0d", nhs5, H_SYNC); end
        checks++;
        if (nhs_out != 0) begin errors++; $display("FAIL hsync_outside got %0d want 0", nhs_out); end
        checks++;
        if (nvs != V_SYNC * H_TOTAL) begin errors++; $display("FAIL vsync_pixels got %0d want %0d", nvs, V_SYNC * H_TOTAL); end
        checks++;
        if (nvs_out != 0) begin errors++; $display("FAIL vsync_outside got %0d want 0", nvs_out); end
    endtask

    task automatic test_freeze();
        int n = 0;
        vec_t want;
        while (!(pix_en0 && cx0 == 8 && cy0 == 3) && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3 * FRAME) begin
            errors++;
            $display("FAIL freeze_wait timeout got none want x=8 y=3");
        end
        run0 = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            checks++;
            if ({pix_en0, cx0, cy0, disp0, ls0, fs0} !== {1'b0, X_W'(8), Y_W'(3), 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL freeze_hold i=%0d got pix=%b x=%0d y=%0d disp=%b want 0 8 3 1", i, pix_en0, cx0, cy0, disp0);
            end
            want = exp_vec(p0, pe0, POL0);
            checks++;
            if (dv0 !== want) begin
                errors++;
                $display("FAIL freeze_model i=%0d got %h want %h", i, dv0, want);
            end
        end
        run0 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_en0 && n < 4);
        checks++;
        if (!pix_en0 || cx0 !== X_W'(9) || cy0 !== Y_W'(3)) begin
            errors++;
            $display("FAIL freeze_resume got pix=%b x=%0d y=%0d want 1 9 3", pix_en0, cx0, cy0);
        end
    endtask

    task automatic test_random_run();
        vec_t want;
        for (int i = 0; i < 3000; i++) begin
            run0 = ($urandom_range(0, 3) != 0);
            run1 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            want = exp_vec(p0, pe0, POL0);
            checks++;
            if (dv0 !== want) begin
                errors++;
                if (errors < 20) $display("FAIL random_model0 i=%0d got %h want %h", i, dv0, want);
            end
            want = exp_vec(p1, pe1, POL1);
            checks++;
            if (dv1 !== want) begin
                errors++;
                if (errors < 20) $display("FAIL random_model1 i=%0d got %h want %h", i, dv1, want);
            end
        end
        run0 = 1'b1;
        run1 = 1'b1;
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (!(pix_en0 && cx0 == 12) && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3 * FRAME) begin
            errors++;
            $display("FAIL async_wait timeout got none want x=12");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dv0 !== RST0) begin
            errors++;
            $display("FAIL async_reset_dut0 got %h want %h", dv0, RST0);
        end
        checks++;
        if (dv1 !== RST1) begin
            errors++;
            $display("FAIL async_reset_dut1 got %h want %h", dv1, RST1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run1  = 1'b1;
        for (int j = 0; j < 2 * H_TOTAL + 5; j++) begin
            @(negedge clk);
            checks++;
            if ({pix_en1, cx1, cy1} !== {1'b1, X_W'(j % H_TOTAL), Y_W'(j / H_TOTAL)}) begin
                errors++;
                $display("FAIL div1_stream j=%0d got pix=%b x=%0d y=%0d want 1 %0d %0d",
                         j, pix_en1, cx1, cy1, j % H_TOTAL, j / H_TOTAL);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_full_frame();
        test_freeze();
        test_random_run();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
